// File: rtl/tile_pkg.sv
// tile_pkg: shared definitions for the 2bpp 8x8 tile format.
// The pixel -> (byte, bit) mapping lives here so the encoder and the display
// decoder use exactly one definition of it.
//   byte_offset(row, col) : byte within the 16-byte tile holding pixel (row, col)
//   pixel_offset(row_lo)  : bit position of the pixel's low plane; high plane is +4
package tile_pkg;

  localparam int unsigned TILE_BYTES  = 16;
  localparam int unsigned TILE_PIXELS = 64;
  localparam int unsigned PIX_W       = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } enc_state_t;

  // Bottom half of the tile (row 4..7) occupies bytes 0..7, top half bytes 8..15;
  // columns run right-to-left within each half.
  function automatic logic [3:0] byte_offset(input logic [2:0] row, input logic [2:0] col);
    return {~row[2], ~col};
  endfunction

  // Only the low two row bits select the bit; row[2] already picked the byte half.
  function automatic logic [1:0] pixel_offset(input logic [1:0] row_lo);
    return row_lo;
  endfunction

endpackage

// File: rtl/tile_pixel_map.sv
// tile_pixel_map: combinational raster position -> tile buffer location.
// Ports:
//   row, col   in  3  pixel position within the 8x8 tile
//   byte_ofs   out 4  destination byte in the tile buffer
//   pixel_ofs  out 2  bit of the low colour plane (high plane at pixel_ofs+4)
module tile_pixel_map
  import tile_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic [3:0] byte_ofs,
  output logic [1:0] pixel_ofs
);

  always_comb begin
    byte_ofs  = byte_offset(row, col);
    pixel_ofs = pixel_offset(row[1:0]);
  end

endmodule

// File: rtl/tile_encoder.sv
// tile_encoder: packs a raster stream of 64 2-bit pixels into a 16-byte 2bpp
// tile and writes the bytes, in order 0..15, to tile RAM.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_valid/pix_ready   pixel handshake; pix_data is the 2-bit colour index
//   tile_idx              destination tile, sampled with pixel 0
//   wr_valid/wr_ready     byte write handshake to tile RAM
//   wr_addr, wr_data      {tile_idx_q, byte_cnt} and the packed byte
//   tile_done             one-cycle pulse after the last byte is accepted
//   busy                  low only when idle in FILL with no pixels collected
module tile_encoder
  import tile_pkg::*;
#(
  parameter int unsigned TILE_IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic [TILE_IDX_W-1:0] tile_idx,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [TILE_IDX_W+3:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  tile_done,
  output logic                  busy
);

  enc_state_t            state;
  logic [5:0]            pix_cnt;
  logic [3:0]            byte_cnt;
  logic [TILE_IDX_W-1:0] tile_idx_q;
  logic [7:0]            tile_buf [TILE_BYTES];

  logic [3:0] byte_ofs;
  logic [1:0] pixel_ofs;
  logic       pix_accept;
  logic       wr_accept;

  tile_pixel_map u_map (
    .row       (pix_cnt[5:3]),
    .col       (pix_cnt[2:0]),
    .byte_ofs  (byte_ofs),
    .pixel_ofs (pixel_ofs)
  );

  assign pix_accept = pix_valid && pix_ready;
  assign wr_accept  = wr_valid && wr_ready;

  // Address/data come straight from flops (buffer, counter, latched index),
  // so they hold steady across wr_ready stalls; forced to zero when not writing.
  assign wr_addr = wr_valid ? {tile_idx_q, byte_cnt} : '0;
  assign wr_data = wr_valid ? tile_buf[byte_cnt] : '0;
  assign busy    = !(state == FILL && pix_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      pix_cnt    <= '0;
      byte_cnt   <= '0;
      tile_idx_q <= '0;
      pix_ready  <= 1'b0;
      wr_valid   <= 1'b0;
      tile_done  <= 1'b0;
      for (int unsigned i = 0; i < TILE_BYTES; i++) begin
        tile_buf[i] <= '0;
      end
    end else begin
      // pix_ready is low throughout DRAIN, so accepts only occur in FILL or DONE;
      // a DONE accept is pixel 0 of the next tile.
      if (pix_accept) begin
        tile_buf[byte_ofs][{1'b0, pixel_ofs}] <= pix_data[0];
        tile_buf[byte_ofs][{1'b1, pixel_ofs}] <= pix_data[1];
        pix_cnt <= pix_cnt + 6'd1;
        if (pix_cnt == '0) begin
          tile_idx_q <= tile_idx;
        end
      end

      case (state)
        FILL: begin
          pix_ready <= 1'b1;
          if (pix_accept && pix_cnt == 6'd63) begin
            state     <= DRAIN;
            pix_ready <= 1'b0;
            wr_valid  <= 1'b1;
          end
        end
        DRAIN: begin
          if (wr_accept) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              state     <= DONE;
              wr_valid  <= 1'b0;
              tile_done <= 1'b1;
              pix_ready <= 1'b1;
              for (int unsigned i = 0; i < TILE_BYTES; i++) begin
                tile_buf[i] <= '0;
              end
            end
          end
        end
        DONE: begin
          state     <= FILL;
          tile_done <= 1'b0;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_encoder.sv
// tb_tile_encoder: directed self-checking bench for tile_encoder.
module tb_tile_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [1:0]  pix_data;
  logic [7:0]  tile_idx;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        tile_done;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [1:0] pix_mem [2][64];
  logic [7:0] exp_bytes [16];

  tile_encoder #(.TILE_IDX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .tile_idx  (tile_idx),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent packing model: bottom half rows -> bytes 0..7, top half -> 8..15,
  // column 7 first; bit = row mod 4 (low plane), +4 (high plane).
  task automatic build_exp(input int sel);
    int b;
    int bi;
    for (int k = 0; k < 16; k++) exp_bytes[k] = 8'h00;
    for (int p = 0; p < 64; p++) begin
      b  = ((p / 8) >= 4 ? 0 : 8) + (7 - (p % 8));
      bi = (p / 8) % 4;
      exp_bytes[b][bi]     = pix_mem[sel][p][0];
      exp_bytes[b][bi + 4] = pix_mem[sel][p][1];
    end
  endtask

  task automatic fill_zero(input int sel);
    for (int p = 0; p < 64; p++) pix_mem[sel][p] = 2'b00;
  endtask

  task automatic fill_rand(input int sel);
    for (int p = 0; p < 64; p++) pix_mem[sel][p] = 2'($urandom);
  endtask

  task automatic feed(input int sel, input logic [7:0] idx, input int start, input bit hold);
    logic acc;
    int   budget;
    for (int i = start; i < 64; i++) begin
      pix_valid = 1'b1;
      pix_data  = pix_mem[sel][i];
      tile_idx  = (i == 0) ? idx : 8'($urandom);
      budget    = 0;
      do begin
        acc      = pix_ready;
        wr_ready = 1'($urandom);
        step();
        budget++;
      end while (!acc && budget < 300);
      if (!acc) check("pix_accept_timeout", 32'(acc), 32'd1);
    end
    if (!hold) begin
      pix_valid = 1'b0;
      pix_data  = 2'($urandom);
    end
  endtask

  task automatic drain(input logic [7:0] idx, input bit stall, input int nbytes);
    int   b;
    int   budget;
    logic acc;
    b      = 0;
    budget = 0;
    check("wr_valid_first", wr_valid, 1);
    check("busy_drain", busy, 1);
    while (b < nbytes && budget < 400) begin
      wr_ready = stall ? 1'($urandom) : 1'b1;
      check("wr_valid", wr_valid, 1);
      check("pix_ready_drain", pix_ready, 0);
      check($sformatf("wr_addr[%0d]", b), wr_addr, {idx, 4'(b)});
      check($sformatf("wr_data[%0d]", b), wr_data, exp_bytes[b]);
      acc = wr_valid && wr_ready;
      step();
      budget++;
      if (acc) b++;
    end
    if (b < nbytes) check("drain_timeout", b, nbytes);
    if (nbytes == 16) begin
      check("tile_done", tile_done, 1);
      check("wr_valid_done", wr_valid, 0);
      check("pix_ready_done", pix_ready, 1);
      step();
      check("tile_done_pulse", tile_done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 2'b00;
    tile_idx  = 8'h00;
    wr_ready  = 1'b0;
    repeat (3) step();
    check("rst_pix_ready", pix_ready, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_pix_ready", pix_ready, 1);
    check("post_rst_busy", busy, 0);

    // All-zero tile to index 5
    fill_zero(0);
    build_exp(0);
    feed(0, 8'h05, 0, 1'b0);
    drain(8'h05, 1'b0, 16);
    check("idle_busy", busy, 0);

    // Random tiles, without and with write stalls
    fill_rand(0);
    build_exp(0);
    feed(0, 8'hA7, 0, 1'b0);
    drain(8'hA7, 1'b0, 16);
    fill_rand(0);
    build_exp(0);
    feed(0, 8'h3C, 0, 1'b0);
    drain(8'h3C, 1'b1, 16);

    // Pixel 0 = 3 -> byte 15 = 0x11
    fill_zero(0);
    pix_mem[0][0] = 2'b11;
    for (int k = 0; k < 16; k++) exp_bytes[k] = 8'h00;
    exp_bytes[15] = 8'h11;
    feed(0, 8'h11, 0, 1'b0);
    drain(8'h11, 1'b0, 16);

    // Pixel 63 = 1 -> byte 0 = 0x08
    fill_zero(0);
    pix_mem[0][63] = 2'b01;
    for (int k = 0; k < 16; k++) exp_bytes[k] = 8'h00;
    exp_bytes[0] = 8'h08;
    feed(0, 8'h22, 0, 1'b0);
    drain(8'h22, 1'b0, 16);

    // pix_valid held across two tiles; next tile's pixel 0 taken in DONE
    fill_rand(0);
    fill_rand(1);
    build_exp(0);
    feed(0, 8'h01, 0, 1'b1);
    pix_data = pix_mem[1][0];
    tile_idx = 8'h02;
    drain(8'h01, 1'b0, 16);
    check("busy_after_done_accept", busy, 1);
    build_exp(1);
    feed(1, 8'h02, 1, 1'b0);
    drain(8'h02, 1'b0, 16);

    // Reset after 7 writes abandons the tile
    fill_rand(0);
    build_exp(0);
    feed(0, 8'h44, 0, 1'b0);
    drain(8'h44, 1'b0, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_valid", wr_valid, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_tile_done", tile_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pix_ready", pix_ready, 0);
    repeat (2) begin
      step();
      check("midrst_no_done", tile_done, 0);
    end
    rst_n = 1'b1;
    step();
    check("midrst_ready_again", pix_ready, 1);
    fill_rand(0);
    build_exp(0);
    feed(0, 8'h77, 0, 1'b0);
    drain(8'h77, 1'b0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
